// File: rtl/lsu_rv32i_if.sv
// Request/response handshake between the execute stage and the load/store unit.
// The execute stage is the master; lsu_rv32i is the slave.
interface lsu_rv32i_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  modport master (
    output req_valid, req_store, req_type, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_store, req_type, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_rv32i.sv
// Load/store sequencer between the RV32I execute stage and data_mem_rv32i:
// validates one request at a time, drives the memory, and extends load data.
module lsu_rv32i #(
  parameter int DMEM_ADDR_BITS = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  lsu_rv32i_if.slave  bus,
  output logic        cu_store,
  output logic [1:0]  cu_storetype,
  output logic [31:0] dmem_addr,
  output logic [31:0] rs2,
  input  logic [31:0] dmem_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    LOAD_DATA,
    RESP
  } state_e;

  state_e      state_q;
  logic        store_q;
  logic [2:0]  type_q;
  logic        respValid_q;
  logic [31:0] respRdata_q;
  logic [1:0]  respErr_q;
  logic        cuStore_q;
  logic [1:0]  cuStoreType_q;
  logic [31:0] dmemAddr_q;
  logic [31:0] rs2_q;

  logic        illegal;
  logic        misaligned;
  logic        outOfRange;
  logic [1:0]  err_d;
  logic [31:0] byteLane;
  logic [15:0] halfLane;
  logic [31:0] rdata_d;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = respValid_q;
  assign bus.resp_rdata = respRdata_q;
  assign bus.resp_err   = respErr_q;
  assign cu_store       = cuStore_q;
  assign cu_storetype   = cuStoreType_q;
  assign dmem_addr      = dmemAddr_q;
  assign rs2            = rs2_q;

  // Request classification; priority is illegal type, then alignment, then range.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    outOfRange = 1'b0;
    err_d      = 2'b00;
    if (bus.req_store) begin
      illegal = !((bus.req_type == 3'b000) || (bus.req_type == 3'b001) ||
                  (bus.req_type == 3'b010));
    end else begin
      illegal = (bus.req_type == 3'b011) || (bus.req_type[2:1] == 2'b11);
    end
    case (bus.req_type[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    outOfRange = |(bus.req_addr >> DMEM_ADDR_BITS);
    if (illegal) begin
      err_d = 2'b11;
    end else if (misaligned) begin
      err_d = 2'b01;
    end else if (outOfRange) begin
      err_d = 2'b10;
    end
  end

  // dmem_addr still holds the load address while the read word is returned.
  always_comb begin
    byteLane = dmem_out >> {dmemAddr_q[1:0], 3'b000};
    halfLane = dmemAddr_q[1] ? dmem_out[31:16] : dmem_out[15:0];
    case (type_q)
      3'b000:  rdata_d = {{24{byteLane[7]}}, byteLane[7:0]};
      3'b100:  rdata_d = {24'h000000, byteLane[7:0]};
      3'b001:  rdata_d = {{16{halfLane[15]}}, halfLane};
      3'b101:  rdata_d = {16'h0000, halfLane};
      default: rdata_d = dmem_out;
    endcase
  end

  // Write enable is a register so an asynchronous reset kills a pending store.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      store_q       <= 1'b0;
      type_q        <= 3'b000;
      respValid_q   <= 1'b0;
      respRdata_q   <= 32'h0;
      respErr_q     <= 2'b00;
      cuStore_q     <= 1'b0;
      cuStoreType_q <= 2'b00;
      dmemAddr_q    <= 32'h0;
      rs2_q         <= 32'h0;
    end else begin
      respValid_q <= 1'b0;
      cuStore_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            store_q     <= bus.req_store;
            type_q      <= bus.req_type;
            respRdata_q <= 32'h0;
            respErr_q   <= 2'b00;
            if (err_d != 2'b00) begin
              respErr_q   <= err_d;
              respValid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              dmemAddr_q    <= bus.req_addr;
              cuStoreType_q <= bus.req_type[1:0];
              if (bus.req_store) begin
                rs2_q     <= bus.req_wdata;
                cuStore_q <= 1'b1;
              end
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (store_q) begin
            respValid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            state_q <= LOAD_DATA;
          end
        end
        LOAD_DATA: begin
          respRdata_q <= rdata_d;
          respValid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rv32i.sv
// Directed bench for lsu_rv32i with a behavioural byte-lane-steering data memory.
module tb_lsu_rv32i;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cuStore;
  logic [1:0]  cuStoreType;
  logic [31:0] dmemAddr;
  logic [31:0] rs2;
  logic [31:0] dmemOut;

  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic [31:0] wordTmp;
  int          storePulses = 0;
  int          assertCount = 0;
  int          failCount   = 0;

  always #5 clock = ~clock;

  lsu_rv32i_if ifc ();

  lsu_rv32i #(.DMEM_ADDR_BITS(10)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (ifc),
    .cu_store     (cuStore),
    .cu_storetype (cuStoreType),
    .dmem_addr    (dmemAddr),
    .rs2          (rs2),
    .dmem_out     (dmemOut)
  );

  // Data memory: writes at the edge closing the enable cycle, 1-cycle read.
  always @(posedge clock) begin
    if (cuStore) begin
      wordTmp = mem[dmemAddr[9:2]];
      case (cuStoreType)
        2'b00:   wordTmp[{dmemAddr[1:0], 3'b000} +: 8] = rs2[7:0];
        2'b01:   wordTmp[{dmemAddr[1], 4'b0000} +: 16] = rs2[15:0];
        default: wordTmp = rs2;
      endcase
      mem[dmemAddr[9:2]] <= wordTmp;
    end
    dmemOut <= mem[dmemAddr[9:2]];
  end

  always @(negedge clock) begin
    if (cuStore) storePulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge with the unit idle; returns at a falling edge in IDLE.
  task automatic applyStimulus(input logic st, input logic [2:0] ty,
                               input logic [31:0] ad, input logic [31:0] wd,
                               output logic [31:0] rd, output logic [1:0] er,
                               output int lat, output int pulses);
    int startPulses;
    startPulses = storePulses;
    rd  = 32'h0;
    er  = 2'b00;
    lat = -1;
    ifc.req_valid = 1'b1;
    ifc.req_store = st;
    ifc.req_type  = ty;
    ifc.req_addr  = ad;
    ifc.req_wdata = wd;
    @(posedge clock);
    #1 ifc.req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (ifc.resp_valid) begin
        rd  = ifc.resp_rdata;
        er  = ifc.resp_err;
        lat = i;
        break;
      end
    end
    @(negedge clock);
    pulses = storePulses - startPulses;
  endtask

  task automatic runCheck(input string tag, input logic st, input logic [2:0] ty,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] expRd, input logic [1:0] expErr,
                          input int expLat, input int expPulses);
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat;
    int          pulses;
    applyStimulus(st, ty, ad, wd, rd, er, lat, pulses);
    checkOutput({tag, ".rdata"}, rd, expRd);
    checkOutput({tag, ".err"}, {30'h0, er}, {30'h0, expErr});
    checkOutput({tag, ".latency"}, lat, expLat);
    checkOutput({tag, ".storePulses"}, pulses, expPulses);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  ty;
    logic [31:0] ad;
    logic [31:0] wd;
  } req_t;

  initial begin
    req_t        b2b [4];
    int          acc;
    int          respCount;
    int          acceptCycle [4];
    logic [31:0] respData [4];
    int          lateResp;

    ifc.req_valid = 1'b0;
    ifc.req_store = 1'b0;
    ifc.req_type  = 3'b000;
    ifc.req_addr  = 32'h0;
    ifc.req_wdata = 32'h0;
    reset_n       = 1'b0;
    #1;
    checkOutput("reset.ready", {31'h0, ifc.req_ready}, 32'h1);
    checkOutput("reset.respValid", {31'h0, ifc.resp_valid}, 32'h0);
    checkOutput("reset.cuStore", {31'h0, cuStore}, 32'h0);
    checkOutput("reset.dmemAddr", dmemAddr, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    runCheck("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00, 2, 1);
    checkOutput("sw10.storeType", {30'h0, cuStoreType}, 32'h2);
    checkOutput("sw10.mem", mem[4], 32'hDEADBEEF);
    runCheck("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 3, 0);

    runCheck("sw10b", 1'b1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 2'b00, 2, 1);
    runCheck("lb12", 1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFFF, 2'b00, 3, 0);
    runCheck("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 2'b00, 3, 0);
    runCheck("lh10", 1'b0, 3'b001, 32'h10, 32'h0, 32'h00007F01, 2'b00, 3, 0);
    runCheck("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h000080FF, 2'b00, 3, 0);
    runCheck("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 2'b00, 3, 0);
    runCheck("lb11", 1'b0, 3'b000, 32'h11, 32'h0, 32'h0000007F, 2'b00, 3, 0);

    runCheck("lw12mis", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 2'b01, 1, 0);
    runCheck("sh13mis", 1'b1, 3'b001, 32'h13, 32'h12345678, 32'h0, 2'b01, 1, 0);
    checkOutput("sh13mis.mem", mem[4], 32'h80FF7F01);
    runCheck("lw400range", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 2'b10, 1, 0);
    runCheck("ld011illegal", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 2'b11, 1, 0);
    runCheck("st100illegal", 1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 2'b11, 1, 0);
    runCheck("ld011at401", 1'b0, 3'b011, 32'h401, 32'h0, 32'h0, 2'b11, 1, 0);
    checkOutput("errors.mem", mem[4], 32'h80FF7F01);

    runCheck("sh12", 1'b1, 3'b001, 32'h12, 32'hAAAA1234, 32'h0, 2'b00, 2, 1);
    runCheck("sb11", 1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0, 2'b00, 2, 1);
    runCheck("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h12345501, 2'b00, 3, 0);

    // Back-to-back with req_valid held high
    b2b[0] = '{1'b1, 3'b010, 32'h40, 32'hCAFEF00D};
    b2b[1] = '{1'b0, 3'b010, 32'h40, 32'h0};
    b2b[2] = '{1'b1, 3'b010, 32'h44, 32'h0BADC0DE};
    b2b[3] = '{1'b0, 3'b010, 32'h44, 32'h0};
    acc       = 0;
    respCount = 0;
    for (int k = 0; k < 4; k++) begin
      acceptCycle[k] = -100;
      respData[k]    = 32'h0;
    end
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (ifc.resp_valid) begin
        if (respCount < 4) respData[respCount] = ifc.resp_rdata;
        respCount++;
      end
      if (acc < 4) begin
        ifc.req_valid = 1'b1;
        ifc.req_store = b2b[acc].st;
        ifc.req_type  = b2b[acc].ty;
        ifc.req_addr  = b2b[acc].ad;
        ifc.req_wdata = b2b[acc].wd;
        if (ifc.req_ready) begin
          acceptCycle[acc] = cyc;
          acc++;
        end
      end else begin
        ifc.req_valid = 1'b0;
      end
      if (acc == 4 && respCount >= 4) break;
      @(negedge clock);
    end
    ifc.req_valid = 1'b0;
    @(negedge clock);
    checkOutput("b2b.accepts", acc, 4);
    checkOutput("b2b.responses", respCount, 4);
    checkOutput("b2b.swToLwSpacing", acceptCycle[1] - acceptCycle[0], 3);
    checkOutput("b2b.lwToSwSpacing", acceptCycle[2] - acceptCycle[1], 4);
    checkOutput("b2b.swToLw2Spacing", acceptCycle[3] - acceptCycle[2], 3);
    checkOutput("b2b.swResp", respData[0], 32'h0);
    checkOutput("b2b.lw40", respData[1], 32'hCAFEF00D);
    checkOutput("b2b.lw44", respData[3], 32'h0BADC0DE);

    // Reset pulse during the ACCESS cycle of a store
    runCheck("sw20", 1'b1, 3'b010, 32'h20, 32'h11111111, 32'h0, 2'b00, 2, 1);
    ifc.req_valid = 1'b1;
    ifc.req_store = 1'b1;
    ifc.req_type  = 3'b010;
    ifc.req_addr  = 32'h20;
    ifc.req_wdata = 32'h22222222;
    @(posedge clock);
    #1 ifc.req_valid = 1'b0;
    checkOutput("rst.cuStoreBefore", {31'h0, cuStore}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst.cuStore", {31'h0, cuStore}, 32'h0);
    checkOutput("rst.ready", {31'h0, ifc.req_ready}, 32'h1);
    checkOutput("rst.respValid", {31'h0, ifc.resp_valid}, 32'h0);
    checkOutput("rst.respRdata", ifc.resp_rdata, 32'h0);
    checkOutput("rst.respErr", {30'h0, ifc.resp_err}, 32'h0);
    checkOutput("rst.storeType", {30'h0, cuStoreType}, 32'h0);
    checkOutput("rst.dmemAddr", dmemAddr, 32'h0);
    checkOutput("rst.rs2", rs2, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    lateResp = 0;
    repeat (4) begin
      @(negedge clock);
      if (ifc.resp_valid) lateResp++;
    end
    checkOutput("rst.noResp", lateResp, 0);
    checkOutput("rst.mem", mem[8], 32'h11111111);
    runCheck("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11111111, 2'b00, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
